// File: rtl/led_pattern_ctrl_if.sv
// Key-event and LED-status bundle for the LED pattern controller.
// master drives key events; slave is the controller side.
interface led_pattern_ctrl_if;
    logic [3:0] key_pulse;
    logic [7:0] leds;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       running;
    logic [3:0] ack;

    modport master (
        output key_pulse,
        input  leds,
        input  mode,
        input  speed,
        input  running,
        input  ack
    );

    modport slave (
        input  key_pulse,
        output leds,
        output mode,
        output speed,
        output running,
        output ack
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED pattern engine: queued key events, mode/speed/run control and a
// speed-scaled tick that auto-advances an 8-bit pattern.
module led_pattern_ctrl #(
    parameter int TICK_DIV = 12_500_000,
    parameter int CNT_W    = 24
) (
    input  logic               clk,
    input  logic               rst,
    led_pattern_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_ROT  = 2'd2
    } mode_e;

    localparam logic [CNT_W-1:0] DIV = CNT_W'(TICK_DIV);

    logic [3:0]       pending_q, pending_d;
    logic [3:0]       grant;
    logic [3:0]       ack_q, ack_d;
    logic [7:0]       leds_q, leds_d;
    mode_e            mode_q, mode_d;
    logic [1:0]       speed_q, speed_d;
    logic             running_q, running_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0] period_m1;
    logic             tick;
    logic             step;
    logic             enter_rot;
    logic [7:0]       stepped;

    // Lowest set bit wins: key0 has the highest priority.
    always_comb begin
        grant = 4'b0000;
        priority case (1'b1)
            pending_q[0]: grant = 4'b0001;
            pending_q[1]: grant = 4'b0010;
            pending_q[2]: grant = 4'b0100;
            pending_q[3]: grant = 4'b1000;
            default:      grant = 4'b0000;
        endcase
    end

    always_comb begin
        pending_d = (pending_q & ~grant) | bus.key_pulse;
        ack_d     = grant;
    end

    // Tick generator
    always_comb begin
        period_m1 = (DIV >> speed_q) - CNT_W'(1);
        tick      = running_q && (tick_cnt_q == period_m1);
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (!running_q) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
        if (grant[2] || grant[3]) begin
            tick_cnt_d = '0;
        end
    end

    // Mode FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_UP;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode FSM: next state
    always_comb begin
        mode_d = mode_q;
        if (grant[1]) begin
            unique case (mode_q)
                MODE_UP:   mode_d = MODE_DOWN;
                MODE_DOWN: mode_d = MODE_ROT;
                MODE_ROT:  mode_d = MODE_UP;
                default:   mode_d = MODE_UP;
            endcase
        end
    end

    // Mode FSM: outputs
    always_comb begin
        enter_rot = grant[1] && (mode_q == MODE_DOWN);
        bus.mode  = mode_q;
    end

    // A grant in a tick cycle replaces the tick's step.
    always_comb begin
        step = grant[0] || (tick && (grant == 4'b0000));
    end

    always_comb begin
        stepped = leds_q;
        unique case (mode_q)
            MODE_UP:   stepped = leds_q + 8'd1;
            MODE_DOWN: stepped = leds_q - 8'd1;
            MODE_ROT:  stepped = {leds_q[6:0], leds_q[7]};
            default:   stepped = leds_q;
        endcase
    end

    always_comb begin
        leds_d    = leds_q;
        speed_d   = speed_q;
        running_d = running_q;
        if (step) begin
            leds_d = stepped;
        end
        if (enter_rot) begin
            leds_d = 8'h01;
        end
        if (grant[2]) begin
            speed_d = speed_q + 2'd1;
        end
        if (grant[3]) begin
            running_d = ~running_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= 4'b0000;
            ack_q      <= 4'b0000;
            leds_q     <= 8'h00;
            speed_q    <= 2'd0;
            running_q  <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            ack_q      <= ack_d;
            leds_q     <= leds_d;
            speed_q    <= speed_d;
            running_q  <= running_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign bus.leds    = leds_q;
    assign bus.speed   = speed_q;
    assign bus.running = running_q;
    assign bus.ack     = ack_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with a cycle-level reference model
// compared against the outputs on every falling edge.
`timescale 1ns/1ps
module tb_led_pattern_ctrl;

    localparam int TDIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_pattern_ctrl_if bus ();

    led_pattern_ctrl #(
        .TICK_DIV (TDIV),
        .CNT_W    (24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: event queue as a bit set, ticks as absolute cycle times.
    longint cyc = 0;
    longint m_next = 0, nx_next;
    int     m_leds = 0, m_mode = 0, m_speed = 0;
    int     nx_leds, nx_mode, nx_speed;
    logic   m_run = 1'b0, nx_run;
    logic [3:0] m_pend = '0, m_ack = '0, nx_pend, nx_ack, g;
    logic   found, tk;
    logic   m_valid = 1'b0;

    function automatic longint per(input int s);
        return longint'(TDIV / (1 << s));
    endfunction

    function automatic int stepv(input int v, input int m);
        if (m == 0) return (v + 1) % 256;
        if (m == 1) return (v + 255) % 256;
        return ((v << 1) | (v >> 7)) & 255;
    endfunction

    always_comb begin
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && m_pend[i]) begin
                g[i]  = 1'b1;
                found = 1'b1;
            end
        end
        tk       = m_run && (cyc == m_next);
        nx_leds  = m_leds;
        nx_mode  = m_mode;
        nx_speed = m_speed;
        nx_run   = m_run;
        nx_next  = m_next;
        if (tk) nx_next = cyc + per(m_speed);
        if (g[0] || (tk && g == 4'b0000)) nx_leds = stepv(m_leds, m_mode);
        if (g[1]) begin
            nx_mode = (m_mode + 1) % 3;
            if (nx_mode == 2) nx_leds = 1;
        end
        if (g[2]) begin
            nx_speed = (m_speed + 1) % 4;
            nx_next  = cyc + per(nx_speed);
        end
        if (g[3]) begin
            nx_run  = !m_run;
            nx_next = cyc + per(m_speed);
        end
        nx_ack  = g;
        nx_pend = (m_pend & ~g) | bus.key_pulse;
        if (rst) begin
            nx_leds  = 0;
            nx_mode  = 0;
            nx_speed = 0;
            nx_run   = 1'b0;
            nx_next  = 0;
            nx_ack   = '0;
            nx_pend  = '0;
        end
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        m_leds  <= nx_leds;
        m_mode  <= nx_mode;
        m_speed <= nx_speed;
        m_run   <= nx_run;
        m_next  <= nx_next;
        m_ack   <= nx_ack;
        m_pend  <= nx_pend;
        m_valid <= m_valid | rst;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (bus.leds !== 8'(m_leds) || bus.mode !== 2'(m_mode) ||
                bus.speed !== 2'(m_speed) || bus.running !== m_run ||
                bus.ack !== m_ack) begin
                errors++;
                $display("FAIL model t=%0t leds=%h/%h mode=%0d/%0d speed=%0d/%0d run=%0b/%0b ack=%b/%b",
                         $time, bus.leds, 8'(m_leds), bus.mode, m_mode,
                         bus.speed, m_speed, bus.running, m_run, bus.ack, m_ack);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk) bus.key_pulse = k;
        @(negedge clk) bus.key_pulse = 4'b0000;
        @(negedge clk) chk("ack", int'(bus.ack), int'(k));
    endtask

    task automatic chk_reset();
        chk("rst_leds", int'(bus.leds), 0);
        chk("rst_mode", int'(bus.mode), 0);
        chk("rst_speed", int'(bus.speed), 0);
        chk("rst_run", int'(bus.running), 0);
        chk("rst_ack", int'(bus.ack), 0);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk_reset();
    endtask

    task automatic chk_period(input int p);
        int l0;
        l0 = int'(bus.leds);
        if (p > 1) begin
            repeat (p - 1) @(negedge clk);
            chk("tick_hold", int'(bus.leds), l0);
        end
        @(negedge clk);
        chk("tick_step", int'(bus.leds), (l0 + 1) % 256);
    endtask

    initial begin
        int l0;
        bus.key_pulse = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset();

        // Step from reset
        press(4'b0001);
        chk("step1", int'(bus.leds), 8'h01);
        repeat (10) press(4'b0001);
        chk("step11", int'(bus.leds), 8'h0B);

        // All four keys at once
        @(negedge clk) bus.key_pulse = 4'b1111;
        @(negedge clk) bus.key_pulse = 4'b0000;
        @(negedge clk) chk("all_ack0", int'(bus.ack), 4'b0001);
        chk("all_leds", int'(bus.leds), 8'h0C);
        @(negedge clk) chk("all_ack1", int'(bus.ack), 4'b0010);
        @(negedge clk) chk("all_ack2", int'(bus.ack), 4'b0100);
        @(negedge clk) chk("all_ack3", int'(bus.ack), 4'b1000);
        chk("all_mode", int'(bus.mode), 1);
        chk("all_speed", int'(bus.speed), 1);
        chk("all_run", int'(bus.running), 1);
        chk("all_leds2", int'(bus.leds), 8'h0C);

        // Mode changes and wrap
        do_reset();
        press(4'b0010);
        chk("mode_down", int'(bus.mode), 1);
        press(4'b0001);
        chk("down_wrap", int'(bus.leds), 8'hFF);
        press(4'b0010);
        chk("mode_rot", int'(bus.mode), 2);
        chk("rot_load", int'(bus.leds), 8'h01);
        for (int i = 0; i < 8; i++) begin
            press(4'b0001);
            chk("rot_step", int'(bus.leds), 1 << ((i + 1) % 8));
        end

        // Auto-run across all speeds
        do_reset();
        press(4'b1000);
        chk("run_on", int'(bus.running), 1);
        chk_period(8);
        chk_period(8);
        press(4'b0100);
        chk_period(4);
        press(4'b0100);
        chk_period(2);
        press(4'b0100);
        chk("speed3", int'(bus.speed), 3);
        chk_period(1);
        chk_period(1);
        press(4'b0100);
        chk("speed_wrap", int'(bus.speed), 0);
        chk_period(8);

        // Key0 grant colliding with a tick at speed 3
        repeat (3) press(4'b0100);
        @(negedge clk) bus.key_pulse = 4'b0001;
        @(negedge clk) bus.key_pulse = 4'b0000;
        l0 = int'(bus.leds);
        @(negedge clk);
        chk("coll_ack", int'(bus.ack), 4'b0001);
        chk("coll_leds", int'(bus.leds), (l0 + 1) % 256);

        // Reset with events queued; a key sampled alongside rst is dropped
        @(negedge clk) bus.key_pulse = 4'b1110;
        @(negedge clk) begin
            bus.key_pulse = 4'b0001;
            rst = 1'b1;
        end
        @(negedge clk) begin
            bus.key_pulse = 4'b0000;
            rst = 1'b0;
        end
        chk_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_ack", int'(bus.ack), 0);
        end
        chk("rst_leds_end", int'(bus.leds), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
